knn_ctrl: RTL and testbench

- Top-level sequencer for one KNN classification query.
- Walks all N training samples through the distance unit, then triggers the K-nearest sorter, then pulses the valid_sort input of the k_type voter.
- Captures inferred_type and returns it to the requester over a valid/ready handshake.
- Owns all inter-stage sequencing; the datapath blocks contain no query-level control.

---
 rtl/knn_pkg.sv | 35 +++
 rtl/knn_watchdog.sv | 35 +++
 rtl/knn_ctrl.sv | 167 ++++++++++++++++
 tb/tb_knn_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
//------------------------------------------------------------------------------
// Module   : knn_pkg
// Brief    : Shared defaults, address width and sequencer state encoding for
//            the KNN query controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package knn_pkg;

  localparam int KNN_N       = 10;
  localparam int KNN_W       = 32;
  localparam int KNN_K       = 5;
  localparam int KNN_TYPE_W  = 4;
  localparam int KNN_TIMEOUT = 255;
  localparam int ADDR_W      = $clog2(KNN_N);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DIST   = 3'd2,
    DWAIT  = 3'd3,
    SWAIT  = 3'd4,
    VWAIT  = 3'd5,
    RESULT = 3'd6
  } state_t;

  // States that block on a datapath handshake and are guarded by the watchdog.
  function automatic logic is_wait_state(input state_t s);
    return (s == DWAIT) || (s == SWAIT) || (s == VWAIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/knn_watchdog.sv
//------------------------------------------------------------------------------
// Module   : knn_watchdog
// Brief    : Per-wait-state cycle counter; flags expiry after TIMEOUT cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module knn_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic restart,
  output logic expire
);

  localparam int                 c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || restart || !active) begin
      r_cnt <= '0;
    end else if (!expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = active && (r_cnt == c_max);

endmodule

`default_nettype wire

// File: rtl/knn_ctrl.sv
//------------------------------------------------------------------------------
// Module   : knn_ctrl
// Brief    : Query-level sequencer: distance pass over N samples, sort, vote,
//            result handshake. Optional watchdog under KNN_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module knn_ctrl
  import knn_pkg::*;
#(
  parameter int N      = KNN_N,
  parameter int TYPE_W = KNN_TYPE_W
`ifdef KNN_TIMEOUT_EN
  , parameter int TIMEOUT = KNN_TIMEOUT
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 query_valid,
  output logic                 query_ready,
  output logic [$clog2(N)-1:0] mem_addr,
  output logic                 mem_rd_en,
  output logic                 dist_en,
  input  logic                 dist_valid,
  output logic                 sort_start,
  input  logic                 sort_done,
  output logic                 valid_sort,
  input  logic                 inference_done,
  input  logic [TYPE_W-1:0]    inferred_type,
  output logic [TYPE_W-1:0]    result_type,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int                  c_addr_w = $clog2(N);
  localparam logic [c_addr_w-1:0] c_last   = c_addr_w'(N - 1);

  state_t              r_state;
  state_t              w_state_n;
  logic [c_addr_w-1:0] r_addr;
  logic [TYPE_W-1:0]   r_result;
  logic                r_sort_start;
  logic                r_valid_sort;
  logic                r_timeout;

  logic w_addr_clr;
  logic w_addr_inc;
  logic w_sort_start;
  logic w_valid_sort;
  logic w_capture;
  logic w_timeout;
  logic w_expire;

`ifdef KNN_TIMEOUT_EN
  knn_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (is_wait_state(r_state)),
    .restart (w_state_n != r_state),
    .expire  (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // A completing handshake always wins over a same-cycle watchdog expiry.
  always_comb begin
    w_state_n    = r_state;
    w_addr_clr   = 1'b0;
    w_addr_inc   = 1'b0;
    w_sort_start = 1'b0;
    w_valid_sort = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (query_valid) begin
          w_addr_clr = 1'b1;
          w_state_n  = FETCH;
        end
      end
      FETCH: w_state_n = DIST;
      DIST:  w_state_n = DWAIT;
      DWAIT: begin
        if (dist_valid) begin
          if (r_addr == c_last) begin
            w_sort_start = 1'b1;
            w_state_n    = SWAIT;
          end else begin
            w_addr_inc = 1'b1;
            w_state_n  = FETCH;
          end
        end else if (w_expire) begin
          w_timeout = 1'b1;
          w_state_n = IDLE;
        end
      end
      SWAIT: begin
        if (sort_done) begin
          w_valid_sort = 1'b1;
          w_state_n    = VWAIT;
        end else if (w_expire) begin
          w_timeout = 1'b1;
          w_state_n = IDLE;
        end
      end
      VWAIT: begin
        if (inference_done) begin
          w_capture = 1'b1;
          w_state_n = RESULT;
        end else if (w_expire) begin
          w_timeout = 1'b1;
          w_state_n = IDLE;
        end
      end
      RESULT: begin
        if (result_ready) begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_result     <= '0;
      r_sort_start <= 1'b0;
      r_valid_sort <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_sort_start <= w_sort_start;
      r_valid_sort <= w_valid_sort;
      r_timeout    <= w_timeout;
      if (w_addr_clr) begin
        r_addr <= '0;
      end else if (w_addr_inc) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_capture) begin
        r_result <= inferred_type;
      end
    end
  end

  assign query_ready  = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign mem_rd_en    = (r_state == FETCH);
  assign dist_en      = (r_state == DIST);
  assign result_valid = (r_state == RESULT);
  assign mem_addr     = r_addr;
  assign result_type  = r_result;
  assign sort_start   = r_sort_start;
  assign valid_sort   = r_valid_sort;
  assign timeout_err  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_knn_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_knn_ctrl
// Brief    : Scoreboard bench for knn_ctrl with behavioural datapath responders.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_knn_ctrl;
  import knn_pkg::*;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       query_valid;
  logic       query_ready;
  logic [3:0] mem_addr;
  logic       mem_rd_en;
  logic       dist_en;
  logic       dist_valid;
  logic       sort_start;
  logic       sort_done;
  logic       valid_sort;
  logic       inference_done;
  logic [3:0] inferred_type;
  logic [3:0] result_type;
  logic       result_valid;
  logic       result_ready;
  logic       busy;
  logic       timeout_err;

  always #5 clk = ~clk;

  knn_ctrl #(
    .N      (N),
    .TYPE_W (4)
`ifdef KNN_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .query_valid    (query_valid),
    .query_ready    (query_ready),
    .mem_addr       (mem_addr),
    .mem_rd_en      (mem_rd_en),
    .dist_en        (dist_en),
    .dist_valid     (dist_valid),
    .sort_start     (sort_start),
    .sort_done      (sort_done),
    .valid_sort     (valid_sort),
    .inference_done (inference_done),
    .inferred_type  (inferred_type),
    .result_type    (result_type),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    logic [3:0] t;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural datapath: distance unit, sorter, voter, plus spurious strobes.
  logic [3:0] vote_type = 4'd7;
  int         dlat      = 1;
  logic       sort_en   = 1'b1;
  logic       spur      = 1'b0;
  int         d_cnt     = 0;
  int         s_cnt     = 0;
  int         v_cnt     = 0;

  initial begin
    dist_valid     = 1'b0;
    sort_done      = 1'b0;
    inference_done = 1'b0;
    inferred_type  = 4'd0;
  end

  always @(negedge clk) begin
    dist_valid     = (d_cnt == 1);
    sort_done      = (s_cnt == 1);
    inference_done = (v_cnt == 1);
    inferred_type  = (v_cnt == 1) ? vote_type : 4'd0;
    if (spur) begin
      if (!busy) dist_valid = 1'b1;
      if (d_cnt == 2) sort_done = 1'b1;
      if (s_cnt == 2) begin
        dist_valid     = 1'b1;
        inference_done = 1'b1;
        inferred_type  = 4'd9;
      end
    end
    if (d_cnt > 0) d_cnt--;
    if (s_cnt > 0) s_cnt--;
    if (v_cnt > 0) v_cnt--;
    if (dist_en) d_cnt = dlat;
    if (sort_start && sort_en) s_cnt = 2;
    if (valid_sort) v_cnt = 3;
  end

  // Monitor: per-query pulse accounting and scoreboard pop on each result.
  int         cyc = 0;
  int         acc_cyc = 0;
  int         exp_addr = 0;
  int         n_rd = 0, n_dist = 0, n_sort = 0, n_vs = 0;
  logic       in_res = 1'b0;
  logic [3:0] held_type = 4'd0;
  logic       to_ok = 1'b0;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    cyc++;
    if (!rst && query_valid && query_ready) begin
      acc_cyc  = cyc;
      exp_addr = 0;
      n_rd = 0; n_dist = 0; n_sort = 0; n_vs = 0;
    end
    if (mem_rd_en) begin
      chk("mem_addr_seq", 32'(mem_addr), 32'(exp_addr));
      exp_addr++;
      n_rd++;
    end
    if (dist_en)    n_dist++;
    if (sort_start) n_sort++;
    if (valid_sort) n_vs++;
    if (result_valid && !in_res) begin
      in_res    = 1'b1;
      held_type = result_type;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result_type", 32'(result_type), 32'(e.t));
        chk("result_latency", 32'(cyc - acc_cyc), 32'(e.lat));
        chk("mem_reads", 32'(n_rd), 32'(N));
        chk("dist_en_pulses", 32'(n_dist), 32'(N));
        chk("sort_start_pulses", 32'(n_sort), 32'd1);
        chk("valid_sort_pulses", 32'(n_vs), 32'd1);
      end
    end else if (result_valid) begin
      chk("result_hold", 32'(result_type), 32'(held_type));
      chk("ready_in_result", 32'(query_ready), 32'd0);
      chk("rd_in_result", 32'(mem_rd_en), 32'd0);
    end
    if (!result_valid || result_ready) in_res = 1'b0;
    if (timeout_err && !to_ok) chk("unexpected_timeout", 32'd1, 32'd0);
  end

  task automatic wait_result(input int lim);
    int i = 0;
    @(negedge clk);
    while (!result_valid && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk("result_wait", 32'(result_valid), 32'd1);
  endtask

  task automatic pulse_query(input logic [3:0] t, input int lat);
    vote_type = t;
    exp_q.push_back('{t: t, lat: lat});
    query_valid = 1'b1;
    @(negedge clk);
    query_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int k;
    int drops;
    int tos;
    rst          = 1'b1;
    query_valid  = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_query_ready", 32'(query_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_result_type", 32'(result_type), 32'd0);
    chk("rst_strobes", {27'd0, mem_rd_en, dist_en, sort_start, valid_sort, result_valid}, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Basic query with 5 cycles of result backpressure, query_valid held.
    vote_type = 4'd7;
    exp_q.push_back('{t: 4'd7, lat: 38});
    query_valid = 1'b1;
    wait_result(100);
    repeat (4) @(negedge clk);
    chk("bp_valid_held", 32'(result_valid), 32'd1);
    chk("bp_type_held", 32'(result_type), 32'd7);
    @(negedge clk);
    vote_type = 4'd3;
    exp_q.push_back('{t: 4'd3, lat: 38});
    result_ready = 1'b1;
    @(negedge clk);
    chk("one_idle_ready", 32'(query_ready), 32'd1);
    @(negedge clk);
    chk("b2b_fetch", 32'(mem_rd_en), 32'd1);
    chk("b2b_addr0", 32'(mem_addr), 32'd0);

    // Back-to-back: ready high on the first result cycle.
    wait_result(100);
    vote_type = 4'd5;
    exp_q.push_back('{t: 4'd5, lat: 38});
    @(negedge clk);
    chk("b2b2_idle", 32'(query_ready), 32'd1);
    @(negedge clk);
    chk("b2b2_fetch", 32'(mem_rd_en), 32'd1);
    chk("b2b2_addr0", 32'(mem_addr), 32'd0);
    query_valid = 1'b0;
    wait_result(100);
    @(negedge clk);
    chk("after_q3_busy", 32'(busy), 32'd0);

    // Reset in the middle of sample 4.
    query_valid = 1'b1;
    @(negedge clk);
    query_valid = 1'b0;
    k = 0;
    while (!(mem_rd_en && mem_addr == 4'd4) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_addr4", 32'(mem_rd_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(query_ready), 32'd1);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_no_result", 32'(result_valid), 32'd0);
    repeat (20) @(negedge clk);
    chk("midrst_still_idle", 32'(busy), 32'd0);
    pulse_query(4'd7, 38);
    wait_result(100);
    @(negedge clk);

    // Spurious strobes outside their wait states, slower distance unit.
    spur = 1'b1;
    dlat = 2;
    repeat (3) begin
      @(negedge clk);
      chk("spur_idle_busy", 32'(busy), 32'd0);
    end
    pulse_query(4'd4, 48);
    wait_result(100);
    @(negedge clk);
    spur = 1'b0;
    dlat = 1;

    // Sorter never answers.
    sort_en = 1'b0;
    query_valid = 1'b1;
    @(negedge clk);
    query_valid = 1'b0;
    k = 0;
    while (!sort_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wd_sort_start", 32'(sort_start), 32'd1);
`ifdef KNN_TIMEOUT_EN
    to_ok = 1'b1;
    k = 0;
    while (!timeout_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wd_delay", 32'(k), 32'd16);
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_no_result", 32'(result_valid), 32'd0);
    @(negedge clk);
    chk("wd_pulse_width", 32'(timeout_err), 32'd0);
    to_ok = 1'b0;
    drops = 0;
    tos = 0;
`else
    drops = 0;
    tos = 0;
    repeat (300) begin
      @(negedge clk);
      if (!busy) drops++;
      if (timeout_err) tos++;
    end
    chk("stay_swait", 32'(drops), 32'd0);
    chk("no_timeout_err", 32'(tos), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wd_rst_idle", 32'(busy), 32'd0);
`endif
    sort_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
